// File: rtl/trend_pkg.sv
// Shared types and helpers for the sample trend monitor.
// Step classes match the out_dir encoding seen by downstream logic.
package trend_pkg;

   typedef enum logic [1:0] {
      FIRST = 2'b00,
      UP    = 2'b01,
      DOWN  = 2'b10,
      FLAT  = 2'b11
   } dir_t;

   typedef enum logic {
      EMPTY = 1'b0,
      TRACK = 1'b1
   } state_t;

   // Increment that sticks at the all-ones value of a width-bit counter.
   function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
      logic [31:0] limit;
      limit = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      return (value >= limit) ? limit : value + 32'd1;
   endfunction

endpackage

// File: rtl/comparator_4Bit.sv
// Existing 4-bit unsigned magnitude comparator: exactly one flag is high.
module comparator_4Bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic       lesser,
   output logic       greater,
   output logic       equal
);

   assign lesser  = (a < b);
   assign greater = (a > b);
   assign equal   = (a == b);

endmodule

// File: rtl/sample_trend_monitor.sv
// Classifies each accepted 4-bit sample against the previous one and keeps
// step counters, run length, trend flags and running min/max behind a valid/ready output.
module sample_trend_monitor
   import trend_pkg::*;
#(
   parameter int CNT_W   = 8,
   parameter int RUN_LEN = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       out_dir,
   output logic [CNT_W-1:0] cnt_up,
   output logic [CNT_W-1:0] cnt_down,
   output logic [CNT_W-1:0] cnt_flat,
   output logic [CNT_W-1:0] run_len,
   output logic             trend_up,
   output logic             trend_down,
   output logic [3:0]       min_val,
   output logic [3:0]       max_val
);

   state_t           state_q, state_d;
   logic [3:0]       prev_q, prev_d;
   logic             mem_valid_q, mem_valid_d;
   dir_t             mem_dir_q, mem_dir_d;
   logic             valid_q, valid_d;
   dir_t             dir_q, dir_d;
   logic [CNT_W-1:0] up_q, up_d;
   logic [CNT_W-1:0] down_q, down_d;
   logic [CNT_W-1:0] flat_q, flat_d;
   logic [CNT_W-1:0] run_q, run_d;
   logic             tup_q, tup_d;
   logic             tdown_q, tdown_d;
   logic [3:0]       min_q, min_d;
   logic [3:0]       max_q, max_d;

   logic lesser, greater, equal;
   logic accept;
   dir_t step_dir;

   comparator_4Bit u_cmp (
      .a       (in_data),
      .b       (prev_q),
      .lesser  (lesser),
      .greater (greater),
      .equal   (equal)
   );

   assign in_ready = !clear && (!valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      step_dir = FLAT;
      if (greater)
         step_dir = UP;
      else if (lesser)
         step_dir = DOWN;
      else if (equal)
         step_dir = FLAT;
   end

   always_comb begin
      state_d     = state_q;
      prev_d      = prev_q;
      mem_valid_d = mem_valid_q;
      mem_dir_d   = mem_dir_q;
      dir_d       = dir_q;
      up_d        = up_q;
      down_d      = down_q;
      flat_d      = flat_q;
      run_d       = run_q;
      tup_d       = tup_q;
      tdown_d     = tdown_q;
      min_d       = min_q;
      max_d       = max_q;
      valid_d     = valid_q;

      if (valid_q && out_ready)
         valid_d = 1'b0;

      if (accept) begin
         valid_d = 1'b1;
         prev_d  = in_data;
         if (state_q == EMPTY) begin
            state_d = TRACK;
            dir_d   = FIRST;
            min_d   = in_data;
            max_d   = in_data;
            tup_d   = 1'b0;
            tdown_d = 1'b0;
         end else begin
            dir_d = step_dir;
            if (in_data < min_q)
               min_d = in_data;
            if (in_data > max_q)
               max_d = in_data;
            // A flat step breaks any run and forgets which way we were going.
            if (step_dir == FLAT) begin
               flat_d      = CNT_W'(sat_inc(32'(flat_q), CNT_W));
               run_d       = '0;
               mem_valid_d = 1'b0;
            end else begin
               if (step_dir == UP)
                  up_d = CNT_W'(sat_inc(32'(up_q), CNT_W));
               else
                  down_d = CNT_W'(sat_inc(32'(down_q), CNT_W));
               if (mem_valid_q && (mem_dir_q == step_dir))
                  run_d = CNT_W'(sat_inc(32'(run_q), CNT_W));
               else
                  run_d = CNT_W'(1);
               mem_valid_d = 1'b1;
               mem_dir_d   = step_dir;
            end
            tup_d   = (step_dir == UP)   && (run_d >= CNT_W'(RUN_LEN));
            tdown_d = (step_dir == DOWN) && (run_d >= CNT_W'(RUN_LEN));
         end
      end
   end

   // Reset and clear both return the block to an empty, all-zero state.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         state_q     <= EMPTY;
         prev_q      <= '0;
         mem_valid_q <= 1'b0;
         mem_dir_q   <= FIRST;
         valid_q     <= 1'b0;
         dir_q       <= FIRST;
         up_q        <= '0;
         down_q      <= '0;
         flat_q      <= '0;
         run_q       <= '0;
         tup_q       <= 1'b0;
         tdown_q     <= 1'b0;
         min_q       <= '0;
         max_q       <= '0;
      end else begin
         state_q     <= state_d;
         prev_q      <= prev_d;
         mem_valid_q <= mem_valid_d;
         mem_dir_q   <= mem_dir_d;
         valid_q     <= valid_d;
         dir_q       <= dir_d;
         up_q        <= up_d;
         down_q      <= down_d;
         flat_q      <= flat_d;
         run_q       <= run_d;
         tup_q       <= tup_d;
         tdown_q     <= tdown_d;
         min_q       <= min_d;
         max_q       <= max_d;
      end
   end

   assign out_valid  = valid_q;
   assign out_dir    = dir_q;
   assign cnt_up     = up_q;
   assign cnt_down   = down_q;
   assign cnt_flat   = flat_q;
   assign run_len    = run_q;
   assign trend_up   = tup_q;
   assign trend_down = tdown_q;
   assign min_val    = min_q;
   assign max_val    = max_q;

endmodule
